bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative double-dabble (shift-add-3).
- Converts a 20-bit binary count (e.g. received-bit or bit-error counter from the QPSK demodulator) into six BCD digits.
- Sits directly upstream of the six-digit seven-segment scan driver and feeds its in0..in5 digit inputs.
- Outputs are held between conversions, so the display never shows intermediate values.

---
 rtl/bin2bcd_seq_pkg.sv | 27 ++
 rtl/bin2bcd_seq_add3.sv | 18 +
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 tb/tb_bin2bcd_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// ============================================================================
// Module   : bin2bcd_seq_pkg
// Purpose  : Shared modem-display constants and FSM encoding for bin2bcd_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bin2bcd_seq_pkg;

  localparam int BIN_W   = 20;
  localparam int DIGITS  = 6;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int SHIFT_W = BCD_W + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W);

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(999999);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
// ============================================================================
// Module   : bcd_add3
// Purpose  : Double-dabble digit correction cell (in >= 5 ? in + 3 : in).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  // Inputs are digits 0..9, so the +3 result never exceeds 4 bits.
  assign out_o = (in_i >= 4'd5) ? (in_i + 4'd3) : in_i;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative 20-bit binary to 6-digit BCD converter (shift-add-3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd4,
  output logic [3:0]       bcd5
);

  state_e             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [BCD_W-1:0]   scratch_adj;
  logic [SHIFT_W-1:0] shift_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (scratch_q[4*g +: 4]),
      .out_o (scratch_adj[4*g +: 4])
    );
  end

  assign shift_d = {scratch_adj, bin_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Saturate so the display shows 999999 rather than wrapped digits.
            if (bin_in > MAX_VAL) begin
              bin_q      <= MAX_VAL;
              ovf_pend_q <= 1'b1;
            end else begin
              bin_q      <= bin_in;
              ovf_pend_q <= 1'b0;
            end
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_q <= shift_d[SHIFT_W-1:BIN_W];
          bin_q     <= shift_d[BIN_W-1:0];
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bcd_q   <= scratch_q;
          ovf_q   <= ovf_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd0 = bcd_q[3:0];
  assign bcd1 = bcd_q[7:4];
  assign bcd2 = bcd_q[11:8];
  assign bcd3 = bcd_q[15:12];
  assign bcd4 = bcd_q[19:16];
  assign bcd5 = bcd_q[23:20];

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq against a decimal model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;
  logic [23:0] bcd_all;

  int n_vec;
  int n_err;

  assign bcd_all = {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

  bin2bcd_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .bcd0   (bcd0),
    .bcd1   (bcd1),
    .bcd2   (bcd2),
    .bcd3   (bcd3),
    .bcd4   (bcd4),
    .bcd5   (bcd5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of min(v, 999999), packed digit5..digit0.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    int unsigned s;
    logic [23:0] r;
    s = (v > 999999) ? 999999 : v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  // Pulses start for one edge, then samples on negedges until done (bounded).
  task automatic run_conv(input logic [19:0] v, output int lat, output int busy_cnt);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, ovf, bcd_all} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h, want all zero",
               busy, done, ovf, bcd_all);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [19:0] vals [3];
    vals[0] = 20'd0;
    vals[1] = 20'd123456;
    vals[2] = 20'd999999;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], lat, bc);
      n_vec++;
      if (lat !== 21) begin
        n_err++;
        $display("FAIL latency_%0d: got %0d cycles, want 21", vals[i], lat);
      end
      n_vec++;
      if (bc !== 21) begin
        n_err++;
        $display("FAIL busy_len_%0d: got %0d cycles, want 21", vals[i], bc);
      end
      n_vec++;
      if ({ovf, bcd_all} !== {1'b0, ref_bcd(int'(vals[i]))}) begin
        n_err++;
        $display("FAIL basic_%0d: got ovf=%b bcd=%h, want ovf=0 bcd=%h",
                 vals[i], ovf, bcd_all, ref_bcd(int'(vals[i])));
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_width_%0d: got done=%b one cycle later, want 0", vals[i], done);
      end
    end
  endtask

  task automatic test_saturation;
    int lat, bc;
    logic [19:0] vals [2];
    vals[0] = 20'hF4240;
    vals[1] = 20'hFFFFF;
    for (int i = 0; i < 2; i++) begin
      run_conv(vals[i], lat, bc);
      n_vec++;
      if ({lat == 21, ovf, bcd_all} !== {1'b1, 1'b1, 24'h999999}) begin
        n_err++;
        $display("FAIL saturate_%h: got lat=%0d ovf=%b bcd=%h, want lat=21 ovf=1 bcd=999999",
                 vals[i], lat, ovf, bcd_all);
      end
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    int done_idx;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd4321;
    @(negedge clk);
    start    = 1'b0;
    dones    = 0;
    done_idx = -1;
    for (int k = 0; k < 26; k++) begin
      if (done === 1'b1) begin
        dones++;
        done_idx = k;
        n_vec++;
        if ({ovf, bcd_all} !== {1'b0, 24'h004321}) begin
          n_err++;
          $display("FAIL ignore_start_result: got ovf=%b bcd=%h, want ovf=0 bcd=004321",
                   ovf, bcd_all);
        end
      end
      if (k == 22) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL start_in_done_cycle: got busy=%b, want 1", busy);
        end
      end
      start = (k == 4 || k == 9 || k == 21);
      bin_in = (k == 21) ? 20'd65 : 20'd777;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (dones !== 1 || done_idx !== 21) begin
      n_err++;
      $display("FAIL ignore_start_done: got %0d pulses (last at %0d), want 1 at 21",
               dones, done_idx);
    end
    begin
      int guard = 0;
      while (done !== 1'b1 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      n_vec++;
      if ({done, bcd_all} !== {1'b1, 24'h000065}) begin
        n_err++;
        $display("FAIL chained_start: got done=%b bcd=%h, want done=1 bcd=000065",
                 done, bcd_all);
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc;
    int saw_done;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd555555;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, ovf, bcd_all} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_abort: got busy=%b done=%b ovf=%b bcd=%h, want all zero",
               busy, done, ovf, bcd_all);
    end
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done === 1'b1) saw_done++;
    end
    n_vec++;
    if (saw_done !== 0 || bcd_all !== 24'd0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d done pulses bcd=%h, want 0 pulses bcd=000000",
               saw_done, bcd_all);
    end
    run_conv(20'd42, lat, bc);
    n_vec++;
    if ({lat == 21, ovf, bcd_all} !== {1'b1, 1'b0, 24'h000042}) begin
      n_err++;
      $display("FAIL after_reset_42: got lat=%0d ovf=%b bcd=%h, want lat=21 ovf=0 bcd=000042",
               lat, ovf, bcd_all);
    end
  endtask

  task automatic test_random;
    logic [23:0] prev_bcd;
    logic        prev_ovf;
    logic [19:0] v;
    logic [23:0] exp_bcd;
    logic        exp_ovf;
    int          lat;
    int          held;
    int          pulses;
    prev_bcd = bcd_all;
    prev_ovf = ovf;
    for (int n = 0; n < 1000; n++) begin
      v = 20'($urandom_range(0, 1048575));
      if (n % 50 == 1) v = 20'(999999 + $urandom_range(0, 2));
      exp_bcd = ref_bcd(int'(v));
      exp_ovf = (int'(v) > 999999);
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(negedge clk);
      start  = 1'b0;
      lat    = 0;
      held   = 1;
      pulses = 0;
      while (done !== 1'b1 && lat < 40) begin
        if (bcd_all !== prev_bcd || ovf !== prev_ovf) held = 0;
        if (lat == 3) bin_in = 20'($urandom);
        if (lat == 7) start = 1'($urandom);
        if (lat == 8) start = 1'b0;
        @(negedge clk);
        lat++;
      end
      n_vec++;
      if (held !== 1) begin
        n_err++;
        $display("FAIL rand_hold_%0d: outputs changed before done, want held at %h", n, prev_bcd);
      end
      n_vec++;
      if ({lat == 21, ovf, bcd_all} !== {1'b1, exp_ovf, exp_bcd}) begin
        n_err++;
        $display("FAIL rand_%0d v=%0d: got lat=%0d ovf=%b bcd=%h, want lat=21 ovf=%b bcd=%h",
                 n, v, lat, ovf, bcd_all, exp_ovf, exp_bcd);
      end
      prev_bcd = exp_bcd;
      prev_ovf = exp_ovf;
      if (n % 97 == 0) begin
        repeat (1 + $urandom_range(0, 4)) begin
          @(negedge clk);
          if (done === 1'b1) pulses++;
          if (bcd_all !== prev_bcd) held = 0;
        end
        n_vec++;
        if (pulses !== 0 || held !== 1) begin
          n_err++;
          $display("FAIL idle_hold_%0d: got %0d extra done pulses held=%0d, want 0 and 1",
                   n, pulses, held);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
